dc_huffman_encoder: RTL and testbench



---
 rtl/dc_huffman_encoder.sv | 164 ++++++++++++++++
 tb/tb_dc_huffman_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_huffman_encoder.sv
// JPEG luminance DC encoder: DPCM difference, category code + magnitude bits,
// MSB-first byte packing with 0xFF->0xFF00 stuffing and a flush/pad sequence.
`timescale 1ns/1ps
module dc_huffman_encoder #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] dc_coef,
  input  logic        pred_clr,
  input  logic        flush,
  output logic        flush_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte
);

  localparam int CW = $clog2(ACC_W + 1);
  localparam logic [ACC_W-1:0] ONES = {ACC_W{1'b1}};

  typedef enum logic [2:0] {S_RUN, S_PAD, S_DRAIN, S_STUFF, S_DONE} state_t;

  state_t           r_state;
  state_t           r_ret;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [10:0]      r_pred;
  logic             r_flush_done;

  logic [10:0]      w_pred_eff;
  logic [11:0]      w_diff;
  logic [11:0]      w_abs;
  logic [11:0]      w_mag_src;
  logic [11:0]      w_mag;
  logic [3:0]       w_cat;
  logic [8:0]       w_code;
  logic [3:0]       w_code_len;
  logic [4:0]       w_sym_len;
  logic [19:0]      w_sym_raw;
  logic [ACC_W-1:0] w_sym_lj;
  logic             w_accept;
  logic             w_shift;
  logic             w_popped_ff;
  logic [ACC_W-1:0] w_acc_sh;
  logic [CW-1:0]    w_cnt_sh;
  logic [ACC_W-1:0] w_acc_app;
  logic [CW-1:0]    w_cnt_app;
  logic [CW-1:0]    w_cnt_pad;
  logic [ACC_W-1:0] w_pad_mask;

  assign in_ready   = (r_state == S_RUN) & ~flush & (r_cnt <= CW'(ACC_W - 20));
  assign out_valid  = (r_state != S_PAD) & ((r_cnt >= CW'(8)) | (r_state == S_STUFF));
  assign out_byte   = (r_state == S_STUFF) ? 8'h00 : r_acc[ACC_W-1 -: 8];
  assign flush_done = r_flush_done;

  assign w_accept    = in_valid & in_ready;
  // STUFF emits its 0x00 without consuming accumulator bits
  assign w_shift     = out_valid & out_ready & (r_state != S_STUFF);
  assign w_popped_ff = (r_acc[ACC_W-1 -: 8] == 8'hFF);

  assign w_pred_eff = pred_clr ? 11'd0 : r_pred;
  assign w_diff     = {dc_coef[10], dc_coef} - {w_pred_eff[10], w_pred_eff};
  assign w_abs      = w_diff[11] ? (12'd0 - w_diff) : w_diff;
  assign w_mag_src  = w_diff[11] ? (w_diff - 12'd1) : w_diff;
  assign w_mag      = w_mag_src & ((12'd1 << w_cat) - 12'd1);

  always_comb begin
    w_cat = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_abs[i]) w_cat = 4'(i + 1);
    end
  end

  always_comb begin
    w_code     = 9'd0;
    w_code_len = 4'd2;
    case (w_cat)
      4'd0:  begin w_code = 9'b000000000; w_code_len = 4'd2; end
      4'd1:  begin w_code = 9'b000000010; w_code_len = 4'd3; end
      4'd2:  begin w_code = 9'b000000011; w_code_len = 4'd3; end
      4'd3:  begin w_code = 9'b000000100; w_code_len = 4'd3; end
      4'd4:  begin w_code = 9'b000000101; w_code_len = 4'd3; end
      4'd5:  begin w_code = 9'b000000110; w_code_len = 4'd3; end
      4'd6:  begin w_code = 9'b000001110; w_code_len = 4'd4; end
      4'd7:  begin w_code = 9'b000011110; w_code_len = 4'd5; end
      4'd8:  begin w_code = 9'b000111110; w_code_len = 4'd6; end
      4'd9:  begin w_code = 9'b001111110; w_code_len = 4'd7; end
      4'd10: begin w_code = 9'b011111110; w_code_len = 4'd8; end
      4'd11: begin w_code = 9'b111111110; w_code_len = 4'd9; end
      default: begin w_code = 9'd0; w_code_len = 4'd2; end
    endcase
  end

  // Symbol is built right-justified, then moved to the top of an ACC_W word
  assign w_sym_len = 5'(w_code_len) + 5'(w_cat);
  assign w_sym_raw = (20'(w_code) << w_cat) | 20'(w_mag);
  assign w_sym_lj  = {w_sym_raw, {(ACC_W-20){1'b0}}} << (5'd20 - w_sym_len);

  // A byte leaving on the same edge frees space before the new symbol lands
  assign w_acc_sh  = w_shift ? (r_acc << 8) : r_acc;
  assign w_cnt_sh  = w_shift ? (r_cnt - CW'(8)) : r_cnt;
  assign w_acc_app = w_acc_sh | (w_sym_lj >> w_cnt_sh);
  assign w_cnt_app = w_cnt_sh + CW'(w_sym_len);

  assign w_cnt_pad  = (r_cnt + CW'(7)) & ~CW'(7);
  assign w_pad_mask = (ONES >> r_cnt) & ~(ONES >> w_cnt_pad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_ret        <= S_RUN;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_pred       <= 11'd0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (pred_clr && (r_state != S_RUN)) r_pred <= 11'd0;
      case (r_state)
        S_RUN: begin
          r_acc <= w_accept ? w_acc_app : w_acc_sh;
          r_cnt <= w_accept ? w_cnt_app : w_cnt_sh;
          if (w_accept)      r_pred <= dc_coef;
          else if (pred_clr) r_pred <= 11'd0;
          if (w_shift && w_popped_ff) begin
            r_state <= S_STUFF;
            r_ret   <= S_RUN;
          end else if (flush) begin
            r_state <= S_PAD;
          end
        end
        S_PAD: begin
          r_acc   <= r_acc | w_pad_mask;
          r_cnt   <= w_cnt_pad;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end else begin
            r_acc <= w_acc_sh;
            r_cnt <= w_cnt_sh;
            if (w_shift && w_popped_ff) begin
              r_state <= S_STUFF;
              r_ret   <= S_DRAIN;
            end
          end
        end
        S_STUFF: begin
          if (out_ready) r_state <= r_ret;
        end
        S_DONE: begin
          r_pred  <= 11'd0;
          r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_huffman_encoder.sv
// Directed bench for dc_huffman_encoder: hand-computed byte streams plus a
// bit-queue reference for the stalled random-coefficient case.
`timescale 1ns/1ps
module tb_dc_huffman_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] dc_coef = 11'd0;
  logic        pred_clr = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;

  dc_huffman_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dc_coef    (dc_coef),
    .pred_clr   (pred_clr),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         done_pulses = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mexp_q[$];
  bit         mbits[$];
  int         m_pred = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_byte);
      if (flush_done) done_pulses++;
    end
  end

  task automatic model_coef(input int coef, input bit clr);
    int diff, a, cat, v, m;
    if (clr) m_pred = 0;
    diff = coef - m_pred;
    m_pred = coef;
    a = (diff < 0) ? -diff : diff;
    cat = 0;
    while (a != 0) begin
      cat++;
      a = a >> 1;
    end
    if (cat == 0) begin
      mbits.push_back(1'b0);
      mbits.push_back(1'b0);
    end else if (cat <= 5) begin
      v = cat + 1;
      mbits.push_back(v[2]);
      mbits.push_back(v[1]);
      mbits.push_back(v[0]);
    end else begin
      for (int j = 0; j < cat - 3; j++) mbits.push_back(1'b1);
      mbits.push_back(1'b0);
    end
    m = (diff >= 0) ? diff : diff - 1;
    for (int b = cat - 1; b >= 0; b--) mbits.push_back(m[b]);
  endtask

  task automatic model_flush();
    logic [7:0] bv;
    while ((mbits.size() % 8) != 0) mbits.push_back(1'b1);
    while (mbits.size() != 0) begin
      bv = 8'h00;
      for (int j = 0; j < 8; j++) bv = {bv[6:0], mbits.pop_front()};
      mexp_q.push_back(bv);
      if (bv == 8'hFF) mexp_q.push_back(8'h00);
    end
    m_pred = 0;
  endtask

  task automatic send(input int coef, input bit clr, input string tag);
    bit ok;
    dc_coef  = 11'(coef);
    pred_clr = clr;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, "_accept"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pred_clr = 1'b0;
    if (ok) model_coef(coef, clr);
  endtask

  task automatic do_flush(input string tag, output int edges);
    bit seen;
    seen = 1'b0;
    edges = -1;
    done_pulses = 0;
    flush = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (flush_done) begin
        seen = 1'b1;
        edges = i - 1;
        break;
      end
    end
    check_val({tag, "_flush_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_flush_done_pulses"}, 32'(done_pulses), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val($sformatf("%s_byte%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'h100, 32'(exp_q[i]));
    end
    $display("stream %s: %0d bytes observed, %0d expected", tag, got_q.size(), exp_q.size());
  endtask

  int         edges;
  int         k;
  int         coef;
  int         pend;
  bit         stalled;
  bit         ok5;
  logic [7:0] hold;
  logic [7:0] first_b;

  initial begin
    // 1: reset state, single zero coefficient, empty flush timing
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_byte", 32'(out_byte), 32'd0);
    check_val("rst_flush_done", 32'(flush_done), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    got_q.delete();
    send(0, 1'b0, "t1");
    do_flush("t1", edges);
    exp_q = {8'h3F};
    check_stream("t1");
    @(negedge clk);
    check_val("t1_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    got_q.delete();
    do_flush("t1e", edges);
    check_val("t1e_done_latency", 32'(edges), 32'd3);
    check_val("t1e_no_bytes", 32'(got_q.size()), 32'd0);

    // 2: diffs +5 and -2
    got_q.delete();
    send(5, 1'b0, "t2a");
    send(3, 1'b0, "t2b");
    do_flush("t2", edges);
    exp_q = {8'h95, 8'hBF};
    check_stream("t2");

    // 3: category 10 with stuffing after the pad byte
    got_q.delete();
    send(1023, 1'b0, "t3");
    do_flush("t3", edges);
    exp_q = {8'hFE, 8'hFF, 8'h00, 8'hFF, 8'h00};
    check_stream("t3");

    // 4: category 11
    got_q.delete();
    send(-1024, 1'b0, "t4");
    do_flush("t4", edges);
    exp_q = {8'hFF, 8'h00, 8'h3F, 8'hFF, 8'h00};
    check_stream("t4");

    // 5: random coefficients under output stall
    got_q.delete();
    mexp_q.delete();
    mbits.delete();
    out_ready = 1'b0;
    k = 0;
    stalled = 1'b0;
    pend = 0;
    while (k < 10 && !stalled) begin
      coef = int'($urandom_range(0, 2047)) - 1024;
      dc_coef  = 11'(coef);
      in_valid = 1'b1;
      @(negedge clk);
      check_val($sformatf("t5_in_ready_%0d", k), 32'(in_ready), 32'(mbits.size() <= 12));
      if (in_ready) begin
        @(posedge clk); #1;
        model_coef(coef, 1'b0);
        k++;
      end else begin
        stalled = 1'b1;
        pend = coef;
      end
    end
    in_valid = stalled;
    first_b = 8'h00;
    for (int j = 0; j < 8; j++) first_b = {first_b[6:0], mbits[j]};
    @(negedge clk);
    hold = out_byte;
    check_val("t5_stall_first_byte", 32'(hold), 32'(first_b));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val($sformatf("t5_stall_valid_%0d", c), 32'(out_valid), 32'd1);
      check_val($sformatf("t5_stall_byte_%0d", c), 32'(out_byte), 32'(hold));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    if (stalled) begin
      ok5 = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok5 = 1'b1;
          break;
        end
      end
      check_val("t5_resume_accept", 32'(ok5), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ok5) model_coef(pend, 1'b0);
      k++;
    end
    while (k < 10) begin
      send(int'($urandom_range(0, 2047)) - 1024, 1'b0, $sformatf("t5_c%0d", k));
      k++;
    end
    do_flush("t5", edges);
    exp_q = mexp_q;
    check_stream("t5");

    // 6: predictor clear with same-cycle accept
    got_q.delete();
    send(5, 1'b0, "t6a");
    send(7, 1'b1, "t6b");
    do_flush("t6", edges);
    exp_q = {8'h96, 8'h7F};
    check_stream("t6");

    // 6b: reset while draining, then a clean restart
    got_q.delete();
    out_ready = 1'b0;
    send(100, 1'b0, "t6c");
    flush = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("t6_drain_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("t6_rst_out_byte", 32'(out_byte), 32'd0);
    flush = 1'b0;
    mbits.delete();
    m_pred = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    send(2, 1'b0, "t6d");
    do_flush("t6d", edges);
    exp_q = {8'h77};
    check_stream("t6d");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
